// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared types and constants for the parallel LFSR. The FSM
//               state type and the Grain-128 LFSR defaults are kept here.
// Revision    : 1.0  initial release
// ============================================================================
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } lfsr_state_t;

    // Grain-128 LFSR feedback taps: bits 0, 7, 38, 70, 81, 96
    localparam logic [127:0] GRAIN128_LFSR_TAPS   = 128'h00000001_00020040_00000040_00000081;
    localparam int           GRAIN128_INIT_ROUNDS = 256;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_par_step.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_par_step
// Description : Purely combinational next-state function of a Fibonacci LFSR
//               advanced by STEP single-bit sub-shifts. Each sub-shift feeds
//               back XOR(state & TAPS), optionally XORed with one injection
//               bit, into the top bit while shifting towards bit 0.
// Ports       : i_state  - current register value
//               i_inj    - injection bits, bit j used by sub-shift j
//               i_inj_en - enables injection (INIT phase)
//               o_next   - register value after STEP sub-shifts
// Revision    : 1.0  initial release
// ============================================================================
module lfsr_par_step #(
    parameter int               WIDTH = 128,
    parameter int               STEP  = 1,
    parameter logic [WIDTH-1:0] TAPS  = '1
) (
    input  logic [WIDTH-1:0] i_state,
    input  logic [STEP-1:0]  i_inj,
    input  logic             i_inj_en,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] w_s;
    logic             w_fb;

    // Unrolled chain: sub-shift j sees the state left by sub-shift j-1.
    always_comb begin
        w_s  = i_state;
        w_fb = 1'b0;
        for (int j = 0; j < STEP; j++) begin
            w_fb = (^(w_s & TAPS)) ^ (i_inj_en & i_inj[j]);
            w_s  = {w_fb, w_s[WIDTH-1:1]};
        end
        o_next = w_s;
    end

endmodule : lfsr_par_step
`default_nettype wire

// File: rtl/lfsr_par.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_par
// Description : Parametrised multi-bit Fibonacci LFSR with init sequencer and
//               valid/ready keystream output. Defaults implement Grain-128.
//               IDLE -> (start_init) -> INIT (INIT_ROUNDS/STEP injected steps)
//               -> RUN (one plain step per accepted handshake).
// Ports       : clk, n_reset (async, active-low)
//               load/data_in  - overwrite register, return to IDLE
//               start_init    - start init sequence (IDLE only)
//               inj_in        - bits XORed into feedback during INIT
//               out_ready     - consumer accepts out_bits
//               out_valid/out_bits - keystream output, bit 0 leaves first
//               busy          - INIT in progress
//               data          - current register state
//               zero_err      - sticky all-zero fault (LFSR_ZERO_GUARD_EN only)
// Options     : define LFSR_ZERO_GUARD_EN to add all-zero state detection.
// Revision    : 1.0  initial release
// ============================================================================
module lfsr_par
    import lfsr_pkg::*;
#(
    parameter int               WIDTH       = 128,
    parameter int               STEP        = 1,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(GRAIN128_LFSR_TAPS),
    parameter int               INIT_ROUNDS = GRAIN128_INIT_ROUNDS
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start_init,
    input  logic [STEP-1:0]  inj_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [STEP-1:0]  out_bits,
    output logic             busy,
    output logic [WIDTH-1:0] data
`ifdef LFSR_ZERO_GUARD_EN
    ,
    output logic             zero_err
`endif
);

    localparam int                  C_CNT_INIT = INIT_ROUNDS / STEP;
    localparam int                  C_CNT_W    = (C_CNT_INIT < 2) ? 1 : $clog2(C_CNT_INIT + 1);
    localparam logic [C_CNT_W-1:0]  C_CNT_LOAD = C_CNT_W'(C_CNT_INIT);
    localparam logic [C_CNT_W-1:0]  C_CNT_ONE  = C_CNT_W'(1);

    lfsr_state_t        r_state;
    logic [WIDTH-1:0]   r_data;
    logic [C_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   w_next;
    logic               w_inj_en;
    logic               w_zero_stop;

    assign w_inj_en = (r_state == INIT);

    lfsr_par_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .TAPS  (TAPS)
    ) u_step (
        .i_state  (r_data),
        .i_inj    (inj_in),
        .i_inj_en (w_inj_en),
        .o_next   (w_next)
    );

`ifdef LFSR_ZERO_GUARD_EN
    logic r_zero_err;

    // A zero state in RUN would emit constant zeros forever; stop instead.
    assign w_zero_stop = (r_state == RUN) && (r_data == '0);
    assign zero_err    = r_zero_err;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_zero_err <= 1'b0;
        end else if (load) begin
            r_zero_err <= 1'b0;
        end else if (w_zero_stop) begin
            r_zero_err <= 1'b1;
        end
    end
`else
    assign w_zero_stop = 1'b0;
`endif

    // Outputs decode registered state only.
    assign out_valid = (r_state == RUN) && !w_zero_stop;
    assign busy      = (r_state == INIT);
    assign out_bits  = r_data[STEP-1:0];
    assign data      = r_data;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_state <= IDLE;
            r_data  <= data_in;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_init) begin
                        if (C_CNT_INIT == 0) begin
                            r_state <= RUN;
                        end else begin
                            r_state <= INIT;
                            r_cnt   <= C_CNT_LOAD;
                        end
                    end
                end
                INIT: begin
                    r_data <= w_next;
                    r_cnt  <= r_cnt - C_CNT_ONE;
                    if (r_cnt == C_CNT_ONE) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_zero_stop) begin
                        r_state <= IDLE;
                    end else if (out_ready) begin
                        r_data <= w_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : lfsr_par
`default_nettype wire

// File: tb/tb_lfsr_par.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_par
// Description : Self-checking bench for lfsr_par. Two instances run side by
//               side: Grain-128 defaults (STEP=1, 256 init rounds) and a
//               STEP=4 variant with no init rounds. A bit-serial reference
//               model tracks both and every output is compared each clock.
//               Zero-guard checks are active when LFSR_ZERO_GUARD_EN is set.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_par;

    localparam logic [127:0] C_TAPS = 128'h00000001_00020040_00000040_00000081;
    localparam int C_M_IDLE = 0;
    localparam int C_M_INIT = 1;
    localparam int C_M_RUN  = 2;

    logic         clk = 1'b0;
    logic         n_reset;

    logic         a_load, a_start, a_ready;
    logic [127:0] a_din;
    logic [0:0]   a_inj;
    logic         a_valid, a_busy;
    logic [0:0]   a_bits;
    logic [127:0] a_data;
    logic         a_zerr;

    logic         b_load, b_start, b_ready;
    logic [127:0] b_din;
    logic [3:0]   b_inj;
    logic         b_valid, b_busy;
    logic [3:0]   b_bits;
    logic [127:0] b_data;
    logic         b_zerr;

    // reference model state
    logic [127:0] ma_data, mb_data;
    int           ma_mode, mb_mode, ma_left, mb_left;
    logic         ma_zerr, mb_zerr;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    lfsr_par #(.WIDTH(128), .STEP(1), .TAPS(C_TAPS), .INIT_ROUNDS(256)) u_a (
        .clk(clk), .n_reset(n_reset), .load(a_load), .data_in(a_din),
        .start_init(a_start), .inj_in(a_inj), .out_ready(a_ready),
        .out_valid(a_valid), .out_bits(a_bits), .busy(a_busy), .data(a_data)
`ifdef LFSR_ZERO_GUARD_EN
        , .zero_err(a_zerr)
`endif
    );

    lfsr_par #(.WIDTH(128), .STEP(4), .TAPS(C_TAPS), .INIT_ROUNDS(0)) u_b (
        .clk(clk), .n_reset(n_reset), .load(b_load), .data_in(b_din),
        .start_init(b_start), .inj_in(b_inj), .out_ready(b_ready),
        .out_valid(b_valid), .out_bits(b_bits), .busy(b_busy), .data(b_data)
`ifdef LFSR_ZERO_GUARD_EN
        , .zero_err(b_zerr)
`endif
    );

`ifndef LFSR_ZERO_GUARD_EN
    assign a_zerr = 1'b0;
    assign b_zerr = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One single-bit shift: parity of tapped bits (plus injection) enters at the top.
    function automatic logic [127:0] shift1(input logic [127:0] s, input logic b);
        logic fb;
        fb = ($countones(s & C_TAPS) % 2 == 1) ^ b;
        return (s >> 1) | ({127'd0, fb} << 127);
    endfunction

    task automatic model_clk(input int step, input int n_init, input logic ld,
                             input logic [127:0] din, input logic st,
                             input logic [3:0] inj, input logic rdy,
                             inout logic [127:0] d, inout int mode,
                             inout int left, inout logic zerr);
        if (ld) begin
            d    = din;
            mode = C_M_IDLE;
            left = 0;
            zerr = 1'b0;
        end else if (mode == C_M_IDLE) begin
            if (st) begin
                mode = (n_init == 0) ? C_M_RUN : C_M_INIT;
                left = n_init;
            end
        end else if (mode == C_M_INIT) begin
            for (int j = 0; j < step; j++) d = shift1(d, inj[j]);
            left = left - step;
            if (left <= 0) mode = C_M_RUN;
        end else begin
`ifdef LFSR_ZERO_GUARD_EN
            if (d == '0) begin
                mode = C_M_IDLE;
                zerr = 1'b1;
            end else
`endif
            if (rdy) begin
                for (int j = 0; j < step; j++) d = shift1(d, 1'b0);
            end
        end
    endtask

    function automatic logic exp_valid(input int mode, input logic [127:0] d);
`ifdef LFSR_ZERO_GUARD_EN
        return (mode == C_M_RUN) && (d != '0);
`else
        return (mode == C_M_RUN);
`endif
    endfunction

    task automatic model_reset();
        ma_data = '0; ma_mode = C_M_IDLE; ma_left = 0; ma_zerr = 1'b0;
        mb_data = '0; mb_mode = C_M_IDLE; mb_left = 0; mb_zerr = 1'b0;
    endtask

    task automatic compare_all();
        check_eq("a_data",  a_data,  ma_data);
        check_eq("a_valid", a_valid, exp_valid(ma_mode, ma_data));
        check_eq("a_busy",  a_busy,  ma_mode == C_M_INIT);
        check_eq("a_bits",  a_bits,  ma_data[0]);
        check_eq("b_data",  b_data,  mb_data);
        check_eq("b_valid", b_valid, exp_valid(mb_mode, mb_data));
        check_eq("b_busy",  b_busy,  mb_mode == C_M_INIT);
        check_eq("b_bits",  b_bits,  mb_data[3:0]);
`ifdef LFSR_ZERO_GUARD_EN
        check_eq("a_zerr",  a_zerr,  ma_zerr);
        check_eq("b_zerr",  b_zerr,  mb_zerr);
`endif
    endtask

    // Advance one clock: model follows the edge, DUT sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!n_reset) begin
            model_reset();
        end else begin
            model_clk(1, 256, a_load, a_din, a_start, {3'b000, a_inj}, a_ready,
                      ma_data, ma_mode, ma_left, ma_zerr);
            model_clk(4, 0, b_load, b_din, b_start, b_inj, b_ready,
                      mb_data, mb_mode, mb_left, mb_zerr);
        end
        @(negedge clk);
        compare_all();
    endtask

    // Count INIT clocks after a start_init on instance A, bounded.
    task automatic measure_init_a(input string tag);
        int nb;
        int first_valid;
        nb = 0;
        first_valid = -1;
        a_start = 1'b1;
        cycle();
        a_start = 1'b0;
        for (int e = 0; e <= 300; e++) begin
            if (a_busy) nb++;
            if (a_valid && first_valid < 0) first_valid = e;
            if (e == 128) check_eq({tag, "_data_c128"}, a_data, ma_data);
            if (first_valid >= 0) break;
            cycle();
        end
        check_eq({tag, "_busy_len"}, nb, 256);
        check_eq({tag, "_valid_edge"}, first_valid, 256);
    endtask

    initial begin
        logic [127:0] snap_d;
        n_reset = 1'b0;
        a_load = 0; a_start = 0; a_ready = 0; a_din = '0; a_inj = '0;
        b_load = 0; b_start = 0; b_ready = 0; b_din = '0; b_inj = '0;
        model_reset();
        @(negedge clk);
        compare_all();
        check_eq("rst_a_data", a_data, 128'd0);
        n_reset = 1'b1;

        // STEP=4, no init rounds: one handshake from 1
        b_load = 1'b1; b_din = 128'h1;
        cycle();
        b_load = 1'b0;
        check_eq("b_bits_load1", b_bits, 4'b0001);
        b_start = 1'b1;
        cycle();
        b_start = 1'b0;
        check_eq("b_valid_run", b_valid, 1'b1);
        b_ready = 1'b1;
        cycle();
        b_ready = 1'b0;
        check_eq("b_one_hs", b_data, 128'h1000_0000_0000_0000_0000_0000_0000_0000);

        // Grain defaults: from zero with constant injection
        a_load = 1'b1; a_din = '0;
        cycle();
        a_load = 1'b0; a_inj = 1'b1; a_ready = 1'b1;
        measure_init_a("inj");

        // backpressure
        a_ready = 1'b0;
        snap_d = ma_data;
        repeat (10) cycle();
        check_eq("hold_data", a_data, snap_d);
        check_eq("hold_bits", a_bits, snap_d[0]);
        check_eq("hold_valid", a_valid, 1'b1);

        // abort at INIT clock 100
        a_inj = 1'b0;
        a_load = 1'b1; a_din = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        a_load = 1'b0;
        a_start = 1'b1;
        cycle();
        a_start = 1'b0;
        repeat (99) cycle();
        check_eq("abort_busy_pre", a_busy, 1'b1);
        a_load = 1'b1; a_din = 128'hA5;
        cycle();
        a_load = 1'b0;
        check_eq("abort_busy", a_busy, 1'b0);
        check_eq("abort_data", a_data, 128'hA5);
        a_inj = 1'b1;
        measure_init_a("reinit");
        a_inj = 1'b0;

        // load and start_init on the same edge: load wins
        a_load = 1'b1; a_start = 1'b1; a_din = 128'h3;
        b_load = 1'b1; b_start = 1'b1; b_din = 128'h3;
        cycle();
        a_load = 1'b0; a_start = 1'b0; b_load = 1'b0; b_start = 1'b0;
        check_eq("ls_a_busy", a_busy, 1'b0);
        check_eq("ls_b_valid", b_valid, 1'b0);

`ifdef LFSR_ZERO_GUARD_EN
        b_load = 1'b1; b_din = '0;
        cycle();
        b_load = 1'b0; b_start = 1'b1;
        cycle();
        b_start = 1'b0; b_ready = 1'b1;
        check_eq("zg_valid", b_valid, 1'b0);
        cycle();
        check_eq("zg_zerr", b_zerr, 1'b1);
        check_eq("zg_valid2", b_valid, 1'b0);
        b_ready = 1'b0;
        b_load = 1'b1; b_din = 128'h1;
        cycle();
        b_load = 1'b0;
        check_eq("zg_clear", b_zerr, 1'b0);
`endif

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            a_load  = ($urandom_range(0, 199) == 0);
            a_din   = {$urandom, $urandom, $urandom, $urandom};
            a_start = ($urandom_range(0, 7) == 0);
            a_inj   = 1'($urandom);
            a_ready = 1'($urandom);
            b_load  = ($urandom_range(0, 19) == 0);
            b_din   = {$urandom, $urandom, $urandom, $urandom};
            b_start = ($urandom_range(0, 3) == 0);
            b_inj   = 4'($urandom);
            b_ready = 1'($urandom);
            cycle();
        end
        a_load = 0; a_start = 0; b_load = 0; b_start = 0;

        // asynchronous reset in the middle of INIT
        a_load = 1'b1; a_din = 128'h1234;
        cycle();
        a_load = 1'b0; a_start = 1'b1;
        cycle();
        a_start = 1'b0;
        repeat (20) cycle();
        check_eq("pre_rst_busy", a_busy, 1'b1);
        #2;
        n_reset = 1'b0;
        #1;
        check_eq("arst_data", a_data, 128'd0);
        check_eq("arst_busy", a_busy, 1'b0);
        check_eq("arst_valid", a_valid, 1'b0);
        check_eq("arst_bits", a_bits, 1'b0);
        check_eq("arst_zerr", a_zerr, 1'b0);
        model_reset();
        cycle();
        n_reset = 1'b1;
        a_start = 1'b1;
        cycle();
        a_start = 1'b0;
        check_eq("post_rst_busy", a_busy, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_lfsr_par
`default_nettype wire
